// File: rtl/feature_map_streamer.sv
// rtl/feature_map_streamer.sv - streams one 8-bit SRAM channel plane as a raster pixel stream
// Optional STREAMER_PAD_BORDER_EN adds a 1-pixel PAD_VALUE border around the stored plane.
module feature_map_streamer #(
  parameter int          IMAGE_WIDTH  = 224,
  parameter int          IMAGE_HEIGHT = 224,
  parameter int          ADDR_W       = 16,
  parameter logic [7:0]  PAD_VALUE    = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              start_frame
);

`ifdef STREAMER_PAD_BORDER_EN
  localparam int COLS = IMAGE_WIDTH + 2;
  localparam int ROWS = IMAGE_HEIGHT + 2;
`else
  localparam int COLS = IMAGE_WIDTH;
  localparam int ROWS = IMAGE_HEIGHT;
`endif
  localparam logic [15:0] COL_LAST = 16'(COLS - 1);
  localparam logic [15:0] ROW_LAST = 16'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SOF, S_STREAM, S_DONE} state_t;

  state_t            state, state_next;
  logic [15:0]       col, row;
  logic              issue_done;
  logic [ADDR_W-1:0] addr;
  logic              rd_pend, pend_pad;
  logic [1:0]        q_count;
  logic [7:0]        q0, q1;
  logic              pop, issue, credit_ok, is_border, last_pop;
  logic [7:0]        push_data;

  assign pixel_valid = (q_count != 2'd0);
  assign pixel_out   = q0;
  assign mem_addr    = addr;
  assign pop         = pixel_valid && pixel_ready;
  assign push_data   = pend_pad ? PAD_VALUE : mem_rd_data;

  // Occupancy after this cycle's pop must leave room for the returning read.
  assign credit_ok = ({1'b0, q_count} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop});
  assign issue     = (state == S_STREAM) && !issue_done && credit_ok;
  assign last_pop  = pop && issue_done && !rd_pend && (q_count == 2'd1);

`ifdef STREAMER_PAD_BORDER_EN
  assign is_border = (row == 16'd0) || (row == ROW_LAST) || (col == 16'd0) || (col == COL_LAST);
`else
  assign is_border = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_SOF;
      S_SOF:    state_next = S_STREAM;
      S_STREAM: if (last_pop) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    start_frame = 1'b0;
    mem_rd_en   = 1'b0;
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    start_frame = (state == S_SOF);
    mem_rd_en   = issue && !is_border;
  end

  // Issue side: raster counters and the next interior address, which is simply sequential.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col        <= 16'd0;
      row        <= 16'd0;
      issue_done <= 1'b0;
      addr       <= '0;
      rd_pend    <= 1'b0;
      pend_pad   <= 1'b0;
    end else begin
      rd_pend  <= issue;
      pend_pad <= issue && is_border;
      if (state == S_IDLE && start) begin
        col        <= 16'd0;
        row        <= 16'd0;
        issue_done <= 1'b0;
        addr       <= base_addr;
      end else if (issue) begin
        if (!is_border) addr <= addr + ADDR_W'(1);
        if (col == COL_LAST) begin
          col <= 16'd0;
          if (row == ROW_LAST) issue_done <= 1'b1;
          else                 row <= row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
    end
  end

  // Two-entry skid queue; q0 is always the head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_count <= 2'd0;
      q0      <= 8'h00;
      q1      <= 8'h00;
    end else begin
      case ({rd_pend, pop})
        2'b10: begin
          if (q_count == 2'd0) q0 <= push_data;
          else                 q1 <= push_data;
          q_count <= q_count + 2'd1;
        end
        2'b01: begin
          q0      <= q1;
          q_count <= q_count - 2'd1;
        end
        2'b11: begin
          if (q_count == 2'd1) begin
            q0 <= push_data;
          end else begin
            q0 <= q1;
            q1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_map_streamer.sv
// tb/tb_feature_map_streamer.sv - directed table-driven bench for feature_map_streamer
module tb_feature_map_streamer;

  localparam int W = 4;
  localparam int H = 3;
`ifdef STREAMER_PAD_BORDER_EN
  localparam int NPIX = (W + 2) * (H + 2);
`else
  localparam int NPIX = W * H;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic       busy, done, mem_rd_en, pixel_valid, start_frame;
  logic [7:0] mem_addr, pixel_out;
  logic [7:0] mem_rd_data = 8'h00;
  logic       pixel_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  feature_map_streamer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(8), .PAD_VALUE(8'h00)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .start_frame(start_frame)
  );

  always #5 clock = ~clock;

  // SRAM model: mem[a] = a, one-cycle read latency
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input logic [7:0] base, input int i);
`ifdef STREAMER_PAD_BORDER_EN
    int r, c;
    r = i / (W + 2);
    c = i % (W + 2);
    if (r == 0 || r == H + 1 || c == 0 || c == W + 1) return 8'h00;
    return base + 8'((r - 1) * W + (c - 1));
`else
    return base + 8'(i);
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_pix"}, pixel_out, 0);
    chk({tag, "_valid"}, pixel_valid, 0);
    chk({tag, "_sof"}, start_frame, 0);
  endtask

  // mode: 0 ready always, 1 random, 2 alternating. abort_at>0 resets after that many handshakes.
  task automatic run_plane(input logic [7:0] base, input int mode, input bit poke,
                           input int abort_at, output logic [7:0] first_px,
                           output logic [7:0] last_px);
    int n = 0, cyc = 0, sf = 0, dn = 0, sf_cyc = -1, first_cyc = -1, last_hs = -1, done_cyc = -1;
    bit pv = 0, pr = 0, fin = 0, poked = 0;
    logic [7:0] pp = 8'h00;
    first_px = 8'h00;
    last_px  = 8'h00;
    @(negedge clock);
    base_addr = base;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!fin && cyc < 300) begin
      case (mode)
        0:       pixel_ready = 1'b1;
        1:       pixel_ready = 1'($urandom_range(0, 1));
        default: pixel_ready = ((cyc % 2) == 0);
      endcase
      #1;
      if (start_frame) begin sf++; sf_cyc = cyc; end
      if (pv && !pr) begin
        chk("stall_valid", pixel_valid, 1);
        chk("stall_hold", pixel_out, pp);
      end
      if (done) begin
        dn++;
        done_cyc = cyc;
        chk("done_after_last", cyc, last_hs + 1);
        if (poke) start = 1'b1;
      end else if (done_cyc >= 0) begin
        chk("busy_low_after_done", busy, 0);
        chk("no_restart", start_frame, 0);
        fin = 1;
      end
      if (pixel_valid && pixel_ready) begin
        if (first_cyc < 0) begin first_cyc = cyc; first_px = pixel_out; end
        chk("pixel", pixel_out, exp_pix(base, n));
        last_px = pixel_out;
        n++;
        last_hs = cyc;
        if (poke && !poked && n == 3) begin start = 1'b1; poked = 1; end
      end
      pv = pixel_valid; pr = pixel_ready; pp = pixel_out;
      if (abort_at > 0 && n == abort_at) begin
        @(posedge clock);
        #1 reset = 1'b1;
        #1 chk_all_zero("abort");
        repeat (3) begin
          @(negedge clock);
          chk("abort_no_done", done, 0);
        end
        reset = 1'b0;
        pixel_ready = 1'b1;
        return;
      end
      @(negedge clock);
      start = 1'b0;
      cyc++;
    end
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL timeout: plane not finished after %0d cycles", cyc);
    end
    chk("pixel_count", n, NPIX);
    chk("sof_pulses", sf, 1);
    chk("done_pulses", dn, 1);
    chk("first_latency_ge2", (first_cyc - sf_cyc) >= 2, 1);
    pixel_ready = 1'b1;
  endtask

  typedef struct {
    logic [7:0] base;
    int         mode;
    bit         poke;
    logic [7:0] first_exp;
    logic [7:0] last_exp;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] fp, lp;

  initial begin
`ifdef STREAMER_PAD_BORDER_EN
    vecs[0] = '{8'h10, 0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{8'h10, 1, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{8'hFE, 0, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{8'h40, 2, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{8'h20, 0, 1'b1, 8'h00, 8'h00};
`else
    vecs[0] = '{8'h10, 0, 1'b0, 8'h10, 8'h1B};
    vecs[1] = '{8'h10, 1, 1'b0, 8'h10, 8'h1B};
    vecs[2] = '{8'hFE, 0, 1'b0, 8'hFE, 8'h09};
    vecs[3] = '{8'h40, 2, 1'b0, 8'h40, 8'h4B};
    vecs[4] = '{8'h20, 0, 1'b1, 8'h20, 8'h2B};
`endif

    // start while reset is held must be ignored
    start = 1'b1;
    base_addr = 8'h33;
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_after_reset", busy, 0);

    for (int i = 0; i < 5; i++) begin
      run_plane(vecs[i].base, vecs[i].mode, vecs[i].poke, 0, fp, lp);
      chk($sformatf("vec%0d_first", i), fp, vecs[i].first_exp);
      chk($sformatf("vec%0d_last", i), lp, vecs[i].last_exp);
    end

    // reset after the 5th handshake, then a fresh plane from the same base
    run_plane(8'h10, 0, 1'b0, 5, fp, lp);
    @(negedge clock);
    chk("idle_after_abort", busy, 0);
    run_plane(8'h10, 0, 1'b0, 0, fp, lp);
`ifdef STREAMER_PAD_BORDER_EN
    chk("restart_first", fp, 8'h00);
`else
    chk("restart_first", fp, 8'h10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
